ic_job_scheduler: RTL and testbench
===================================

Name: ic_job_scheduler

Overview:
- Sits between the ray-tracing (RT) cores and the intersection (IC) cores, alongside patch_dispatcher.
- Accepts thread hand-off requests from NUM_RT RT cores using round-robin arbitration, one per cycle.
- Buffers accepted thread IDs in an in-order pending FIFO.
- Dispatches each buffered thread to the lowest-indexed free IC core and tracks IC busy state until that core reports done.

Parameters:
NUM_THREAD, 32, thread count; FIFO depth = NUM_THREAD; BIT_THREAD = $clog2(NUM_THREAD)
NUM_RT, 4, number of RT cores
NUM_IC, 4, number of IC cores

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_rt  in  NUM_RT  per-RT request to hand off a thread; held until granted
thread_id_in_rt  in  NUM_RT x BIT_THREAD  thread ID per RT request (unpacked array)
grant_rt  out  NUM_RT  combinational one-hot accept, same cycle as accepted req
done_ic  in  NUM_IC  single-cycle pulse: IC j finished its thread
job_dispatch_ic  out  NUM_IC  registered one-hot pulse: IC j takes thread_id_out_ic
thread_id_out_ic  out  BIT_THREAD  registered thread ID, valid with job_dispatch_ic
fifo_count  out  BIT_THREAD+1  registered pending-FIFO occupancy
ic_busy  out  NUM_IC  registered busy bit per IC
idle  out  1  combinational: fifo_count==0 and ic_busy==0

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - FIFO pointers and fifo_count = 0.
  - RR pointer = 0.
  - ic_busy = 0.
  - job_dispatch_ic = 0; thread_id_out_ic = 0.
  - grant_rt is forced to 0 while rst=1.
  - Reset mid-operation discards all pending threads and busy state; no dispatch pulse follows.
- Arbitration (combinational):
  - If fifo_count==NUM_THREAD, grant_rt = 0 (full check ignores a same-cycle pop).
  - Otherwise, grant the first requesting index found scanning rr_ptr, rr_ptr+1, ... mod NUM_RT.
  - On grant to i: push thread_id_in_rt[i]; rr_ptr <= (i+1) mod NUM_RT.
  - With no grant, rr_ptr is unchanged.
- FIFO:
  - Circular; read/write pointers wrap at NUM_THREAD.
  - At most 1 push and 1 pop per cycle.
  - fifo_count updates +1 (push only), -1 (pop only), or 0 (both or neither).
  - No bypass: a pushed entry is poppable no earlier than the next cycle.
- Dispatch:
  - When fifo_count!=0 and any ic_busy bit is 0, pick the lowest index j with ic_busy[j]=0 and pop the head.
  - Next edge: job_dispatch_ic = one-hot j, thread_id_out_ic = head, ic_busy[j] <= 1.
  - job_dispatch_ic is 0 in every other cycle; thread_id_out_ic holds its last value.
- Latency: grant in cycle N -> job_dispatch_ic visible in cycle N+2 (FIFO empty, an IC free).
- Completion:
  - done_ic[j] with ic_busy[j]=1 clears ic_busy[j] at the next edge; IC j is selectable from that cycle on.
  - done_ic[j] on a non-busy IC is ignored.
  - Done and dispatch for different ICs in the same cycle both take effect.
- Ordering: dispatch order equals grant order (FIFO). Each IC holds at most one thread.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req_rt=1 -> grant_rt=0, job_dispatch_ic=0, fifo_count=0, ic_busy=0, idle=1.
- Single hand-off: req_rt[2]=1, id=5'd7 at cycle N -> grant_rt=4'b0100 in N; job_dispatch_ic=4'b0001, thread_id_out_ic=7 in N+2; ic_busy=4'b0001.
- Round-robin fairness: all 4 RT request continuously with ids 1,2,3,4 -> grants 0,1,2,3,0,...; dispatches to IC0..IC3 carry ids 1,2,3,4 in that order.
- IC saturation and release:
  - With 4 ICs busy and 3 pending, no dispatch occurs.
  - Pulse done_ic[2] in cycle M -> job_dispatch_ic=4'b0100 at M+2 with the oldest pending id; fifo_count drops by 1.
- FIFO full/wrap:
  - Keep ICs busy and push 32 ids -> fifo_count=32 and grant_rt=0 while full.
  - Release ICs -> 32 ids dispatch in push order.
  - Continue 40 further pushes to verify pointer wrap.
- Reset mid-operation: assert rst with fifo_count=5 and ic_busy=4'b1011 -> all cleared next cycle; later done_ic pulses are ignored and no dispatch occurs.

Source files
------------

// File: rtl/ic_job_scheduler.sv
// Hands RT-core threads to IC cores: RR-arbitrated accept into an in-order FIFO, then lowest-free-IC dispatch.
// Latency: grant in cycle N -> registered dispatch pulse in N+2 when the FIFO is empty and an IC is free.
// Backpressure: grants stop while the FIFO is full; threads wait in the FIFO while every IC is busy.
module ic_job_scheduler #(
    parameter int NUM_THREAD = 32,
    parameter int NUM_RT     = 4,
    parameter int NUM_IC     = 4,
    parameter int BIT_THREAD = $clog2(NUM_THREAD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_RT-1:0]     req_rt,
    input  logic [BIT_THREAD-1:0] thread_id_in_rt [NUM_RT],
    output logic [NUM_RT-1:0]     grant_rt,
    input  logic [NUM_IC-1:0]     done_ic,
    output logic [NUM_IC-1:0]     job_dispatch_ic,
    output logic [BIT_THREAD-1:0] thread_id_out_ic,
    output logic [BIT_THREAD:0]   fifo_count,
    output logic [NUM_IC-1:0]     ic_busy,
    output logic                  idle
);
    localparam int RR_W = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;
    localparam logic [BIT_THREAD:0]   FULL     = (BIT_THREAD + 1)'(NUM_THREAD);
    localparam logic [BIT_THREAD-1:0] PTR_LAST = BIT_THREAD'(NUM_THREAD - 1);
    localparam logic [RR_W-1:0]       RR_LAST  = RR_W'(NUM_RT - 1);

    logic [BIT_THREAD-1:0] mem_q [NUM_THREAD];
    logic [BIT_THREAD-1:0] mem_d [NUM_THREAD];
    logic [BIT_THREAD-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BIT_THREAD:0]   count_q, count_d;
    logic [RR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_IC-1:0]     ic_busy_q, ic_busy_d;
    logic [NUM_IC-1:0]     dispatch_q, dispatch_d;
    logic [BIT_THREAD-1:0] tid_out_q, tid_out_d;

    logic                  push;
    logic [BIT_THREAD-1:0] push_id;
    logic [RR_W-1:0]       arb_idx;
    logic                  pop;
    logic [NUM_IC-1:0]     pick;

    // Round-robin scan starting at rr_ptr; the full check deliberately ignores a same-cycle pop.
    always_comb begin
        grant_rt = '0;
        push     = 1'b0;
        push_id  = '0;
        arb_idx  = '0;
        rr_ptr_d = rr_ptr_q;
        if (!rst && count_q != FULL) begin
            for (int k = 0; k < NUM_RT; k++) begin
                arb_idx = RR_W'((int'(rr_ptr_q) + k) % NUM_RT);
                if (!push && req_rt[arb_idx]) begin
                    push              = 1'b1;
                    grant_rt[arb_idx] = 1'b1;
                    push_id           = thread_id_in_rt[arb_idx];
                    rr_ptr_d          = (arb_idx == RR_LAST) ? '0 : arb_idx + RR_W'(1);
                end
            end
        end
    end

    // Lowest-indexed free IC takes the FIFO head; a fresh push is not visible here until next cycle.
    always_comb begin
        pick = '0;
        for (int j = NUM_IC - 1; j >= 0; j--) begin
            if (!ic_busy_q[j]) begin
                pick    = '0;
                pick[j] = 1'b1;
            end
        end
        pop = (count_q != '0) && (pick != '0);
    end

    // Next-state for FIFO storage, pointers, occupancy, busy tracking and the dispatch pulse.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_id;
        end
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + BIT_THREAD'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + BIT_THREAD'(1);
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (BIT_THREAD + 1)'(1);
            2'b01:   count_d = count_q - (BIT_THREAD + 1)'(1);
            default: count_d = count_q;
        endcase
        // done on an idle IC is masked out naturally; done and dispatch never hit the same IC
        ic_busy_d  = (ic_busy_q & ~done_ic) | (pop ? pick : '0);
        dispatch_d = pop ? pick : '0;
        tid_out_d  = pop ? mem_q[rd_ptr_q] : tid_out_q;
    end

    // Control state with synchronous reset; pending threads and busy state are discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            ic_busy_q  <= '0;
            dispatch_q <= '0;
            tid_out_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            ic_busy_q  <= ic_busy_d;
            dispatch_q <= dispatch_d;
            tid_out_q  <= tid_out_d;
        end
    end

    // FIFO payload needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign job_dispatch_ic  = dispatch_q;
    assign thread_id_out_ic = tid_out_q;
    assign fifo_count       = count_q;
    assign ic_busy          = ic_busy_q;
    assign idle             = (count_q == '0) && (ic_busy_q == '0);

endmodule

// File: tb/tb_ic_job_scheduler.sv
// Self-checking bench for ic_job_scheduler: cycle model plus a thread-ID scoreboard.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// The model predicts grants, occupancy and busy bits; dispatched IDs are popped from the scoreboard.
module tb_ic_job_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_rt = '0;
    logic [4:0] tid_in [4];
    logic [3:0] grant_rt;
    logic [3:0] done_ic = '0;
    logic [3:0] job_dispatch_ic;
    logic [4:0] thread_id_out_ic;
    logic [5:0] fifo_count;
    logic [3:0] ic_busy;
    logic       idle;

    int         tests = 0;
    int         fails = 0;
    int         ndisp = 0;

    // reference model state (updated once per cycle on the falling edge)
    int         m_cnt = 0;
    int         m_rr = 0;
    logic [3:0] m_busy = '0;
    logic [3:0] m_disp = '0;
    logic [3:0] last_grant = '0;
    logic [4:0] sb [$];

    ic_job_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .req_rt           (req_rt),
        .thread_id_in_rt  (tid_in),
        .grant_rt         (grant_rt),
        .done_ic          (done_ic),
        .job_dispatch_ic  (job_dispatch_ic),
        .thread_id_out_ic (thread_id_out_ic),
        .fifo_count       (fifo_count),
        .ic_busy          (ic_busy),
        .idle             (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model across the coming rising edge.
    always @(negedge clk) begin
        logic [3:0] eg;
        logic [3:0] pick;
        logic       pp;
        int         idx;
        eg = '0;
        if (!rst && m_cnt != 32) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_rr + k) % 4;
                if (eg == 4'b0 && req_rt[idx]) eg[idx] = 1'b1;
            end
        end
        check("grant", grant_rt, eg);
        check("dispatch", job_dispatch_ic, m_disp);
        check("count", fifo_count, m_cnt);
        check("busy", ic_busy, m_busy);
        check("idle", idle, (m_cnt == 0 && m_busy == 4'b0));
        if (job_dispatch_ic != 4'b0) begin
            ndisp++;
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else                check("tid", thread_id_out_ic, sb.pop_front());
        end
        if (rst) begin
            m_cnt  = 0;
            m_rr   = 0;
            m_busy = '0;
            m_disp = '0;
            sb.delete();
        end else begin
            pick = '0;
            for (int j = 3; j >= 0; j--) if (!m_busy[j]) pick = 4'b0001 << j;
            pp     = (m_cnt != 0) && (pick != 4'b0);
            m_busy = (m_busy & ~done_ic) | (pp ? pick : 4'b0);
            m_disp = pp ? pick : 4'b0;
            m_cnt  = m_cnt + ((eg != 4'b0) ? 1 : 0) - (pp ? 1 : 0);
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) begin
                    sb.push_back(tid_in[i]);
                    m_rr = (i + 1) % 4;
                end
            end
        end
        last_grant = eg;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random traffic: a request is held until granted, then replaced by a fresh one (or none).
    task automatic drive_rand(input int n, input int req_pct, input int done_pct);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_rt[i] || last_grant[i]) begin
                    req_rt[i] = ($urandom_range(0, 99) < req_pct);
                    tid_in[i] = 5'($urandom);
                end
                done_ic[i] = ($urandom_range(0, 99) < done_pct);
            end
            tick();
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 4; i++) tid_in[i] = 5'(i + 1);

        // reset with every RT requesting
        req_rt = 4'hf;
        repeat (2) tick();
        check("rst_grant", grant_rt, 4'h0);
        check("rst_idle", idle, 1);
        rst    = 1'b0;
        req_rt = 4'h0;
        tick();

        // single hand-off from RT2, id 7: dispatch to IC0 two cycles after grant
        req_rt    = 4'b0100;
        tid_in[2] = 5'd7;
        #3;
        check("single_grant", grant_rt, 4'b0100);
        tick();
        req_rt = 4'h0;
        tick();
        check("single_disp", job_dispatch_ic, 4'b0001);
        check("single_tid", thread_id_out_ic, 7);
        check("single_busy", ic_busy, 4'b0001);
        done_ic = 4'b0001;
        tick();
        done_ic = 4'b0000;
        tick();

        // round-robin with all RTs requesting: 7 grants, 4 dispatched, 3 pending
        for (int i = 0; i < 4; i++) tid_in[i] = 5'(i + 1);
        req_rt = 4'hf;
        repeat (7) tick();
        req_rt = 4'h0;
        repeat (3) tick();
        check("sat_cnt", fifo_count, 3);
        check("sat_busy", ic_busy, 4'hf);
        check("sat_nodisp", job_dispatch_ic, 4'h0);
        done_ic = 4'b0100;
        tick();
        done_ic = 4'b0000;
        tick();
        check("rel_disp", job_dispatch_ic, 4'b0100);
        check("rel_cnt", fifo_count, 2);

        // fill the FIFO with every IC busy
        guard = 0;
        while (fifo_count != 6'd32 && guard < 200) begin
            drive_rand(1, 100, 0);
            guard++;
        end
        check("full_reach", fifo_count, 32);
        drive_rand(3, 100, 0);
        check("full_grant", grant_rt, 4'h0);
        check("full_cnt", fifo_count, 32);

        // release ICs, keep pushing so the pointers wrap several times
        drive_rand(400, 70, 40);
        req_rt  = 4'h0;
        done_ic = 4'hf;
        repeat (80) tick();
        done_ic = 4'h0;
        tick();
        check("drain_idle", idle, 1);
        check("drain_sb", sb.size(), 0);

        // mid-operation reset with pending threads and busy ICs
        guard = 0;
        while (fifo_count < 6'd5 && guard < 100) begin
            drive_rand(1, 100, 0);
            guard++;
        end
        check("mr_setup", (fifo_count >= 6'd5), 1);
        req_rt = 4'h0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_cnt", fifo_count, 0);
        check("mr_busy", ic_busy, 4'h0);
        check("mr_disp", job_dispatch_ic, 4'h0);
        done_ic = 4'hf;
        repeat (3) tick();
        done_ic = 4'h0;
        repeat (2) tick();
        check("mr_idle", idle, 1);

        check("ndisp_min", (ndisp >= 60), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
